// File: rtl/preemption_timer.sv
// Time-slice controller: counts retired user instructions against an OS quantum
// and raises a one-cycle timer or halt request with a latched resume PC and cause.
module preemption_timer #(
    parameter int PC_WIDTH    = 11,
    parameter int Q_WIDTH     = 16,
    parameter int MIN_QUANTUM = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                set,
    input  logic [Q_WIDTH-1:0]  quantum,
    input  logic                count_en,
    input  logic                halt,
    input  logic                ack,
    input  logic [PC_WIDTH-1:0] next_pc,
    output logic                int_clk,
    output logic                int_halt,
    output logic [1:0]          cause,
    output logic [PC_WIDTH-1:0] saved_pc,
    output logic                armed,
    output logic [Q_WIDTH-1:0]  remaining
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COUNTING = 2'd1;
    localparam logic [1:0] PENDING  = 2'd2;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_TIMER = 2'd1;
    localparam logic [1:0] CAUSE_HALT  = 2'd2;

    localparam logic [Q_WIDTH-1:0] ZERO = '0;
    localparam logic [Q_WIDTH-1:0] ONE  = {{(Q_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [Q_WIDTH-1:0] MINQ = Q_WIDTH'(MIN_QUANTUM);

    logic [1:0]         state;
    logic [Q_WIDTH-1:0] lq;

    // Nonzero quanta below the minimum are clamped so a slice always runs
    always_comb begin
        lq = quantum;
        if (quantum == ZERO) begin
            lq = ZERO;
        end else if (quantum < MINQ) begin
            lq = MINQ;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            int_clk   <= 1'b0;
            int_halt  <= 1'b0;
            cause     <= CAUSE_NONE;
            saved_pc  <= '0;
            armed     <= 1'b0;
            remaining <= ZERO;
        end else begin
            int_clk  <= 1'b0;
            int_halt <= 1'b0;
            case (state)
                IDLE: begin
                    if (set && lq != ZERO) begin
                        state     <= COUNTING;
                        armed     <= 1'b1;
                        remaining <= lq;
                    end
                end
                COUNTING: begin
                    if (halt) begin
                        int_halt <= 1'b1;
                        cause    <= CAUSE_HALT;
                        saved_pc <= next_pc;
                        state    <= PENDING;
                        armed    <= 1'b0;
                    end else if (set) begin
                        remaining <= lq;
                        if (lq == ZERO) begin
                            state <= IDLE;
                            armed <= 1'b0;
                        end
                    end else if (count_en) begin
                        if (remaining == ONE) begin
                            int_clk   <= 1'b1;
                            cause     <= CAUSE_TIMER;
                            saved_pc  <= next_pc;
                            remaining <= ZERO;
                            state     <= PENDING;
                            armed     <= 1'b0;
                        end else if (remaining != ZERO) begin
                            remaining <= remaining - ONE;
                        end
                    end
                end
                PENDING: begin
                    // GETINT may carry a fresh SETCLOCK in the same cycle
                    if (ack) begin
                        cause <= CAUSE_NONE;
                        state <= IDLE;
                        if (set && lq != ZERO) begin
                            state     <= COUNTING;
                            armed     <= 1'b1;
                            remaining <= lq;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    armed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_preemption_timer.sv
// Directed vector table plus hand-written multi-cycle sequences
// for the preemption timer.
module tb_preemption_timer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        set;
    logic [15:0] quantum;
    logic        count_en;
    logic        halt;
    logic        ack;
    logic [10:0] next_pc;
    logic        int_clk;
    logic        int_halt;
    logic [1:0]  cause;
    logic [10:0] saved_pc;
    logic        armed;
    logic [15:0] remaining;

    int tests  = 0;
    int failed = 0;

    always #5 Clock = ~Clock;

    preemption_timer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .set       (set),
        .quantum   (quantum),
        .count_en  (count_en),
        .halt      (halt),
        .ack       (ack),
        .next_pc   (next_pc),
        .int_clk   (int_clk),
        .int_halt  (int_halt),
        .cause     (cause),
        .saved_pc  (saved_pc),
        .armed     (armed),
        .remaining (remaining)
    );

    typedef struct {
        logic        rst;
        logic        st;
        logic [15:0] q;
        logic        ce;
        logic        h;
        logic        a;
        logic [10:0] pc;
        logic        e_iclk;
        logic        e_ihalt;
        logic [1:0]  e_cause;
        logic [10:0] e_spc;
        logic        e_armed;
        logic [15:0] e_rem;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [15:0] q,
                        input logic ce, input logic h, input logic a,
                        input logic [10:0] pc);
        Reset    = r;
        set      = s;
        quantum  = q;
        count_en = ce;
        halt     = h;
        ack      = a;
        next_pc  = pc;
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic iclk,
                             input logic ihalt, input logic [1:0] c,
                             input logic [10:0] spc, input logic arm,
                             input logic [15:0] rem);
        check({tag, ".int_clk"},   16'(int_clk),   16'(iclk));
        check({tag, ".int_halt"},  16'(int_halt),  16'(ihalt));
        check({tag, ".cause"},     16'(cause),     16'(c));
        check({tag, ".saved_pc"},  16'(saved_pc),  16'(spc));
        check({tag, ".armed"},     16'(armed),     16'(arm));
        check({tag, ".remaining"}, remaining,      rem);
    endtask

    initial begin
        logic ce_pat[7];
        logic [15:0] rem_exp[7];
        logic clk_exp[7];

        // rst st q ce h a pc | iclk ihalt cause spc armed rem
        vecs.push_back('{1,0,16'd0,0,0,0,11'h000, 0,0,0,11'h000,0,16'd0});
        vecs.push_back('{0,1,16'd5,1,0,0,11'h000, 0,0,0,11'h000,1,16'd5});
        vecs.push_back('{0,0,16'd0,1,0,0,11'h000, 0,0,0,11'h000,1,16'd4});
        vecs.push_back('{0,0,16'd0,1,0,0,11'h000, 0,0,0,11'h000,1,16'd3});
        vecs.push_back('{0,0,16'd0,1,0,0,11'h000, 0,0,0,11'h000,1,16'd2});
        vecs.push_back('{0,0,16'd0,1,0,0,11'h000, 0,0,0,11'h000,1,16'd1});
        vecs.push_back('{0,0,16'd0,1,0,0,11'h02A, 1,0,1,11'h02A,0,16'd0});
        vecs.push_back('{0,0,16'd0,1,0,0,11'h000, 0,0,1,11'h02A,0,16'd0});
        vecs.push_back('{0,0,16'd0,0,0,1,11'h000, 0,0,0,11'h02A,0,16'd0});
        vecs.push_back('{0,1,16'd1,0,0,0,11'h000, 0,0,0,11'h02A,1,16'd2});
        vecs.push_back('{0,0,16'd0,1,0,0,11'h000, 0,0,0,11'h02A,1,16'd1});
        vecs.push_back('{0,0,16'd0,1,1,0,11'h100, 0,1,2,11'h100,0,16'd1});
        vecs.push_back('{0,0,16'd0,0,0,0,11'h000, 0,0,2,11'h100,0,16'd1});
        vecs.push_back('{0,1,16'd9,1,1,0,11'h055, 0,0,2,11'h100,0,16'd1});
        vecs.push_back('{0,1,16'd9,0,0,1,11'h000, 0,0,0,11'h100,1,16'd9});
        vecs.push_back('{0,0,16'd0,1,0,0,11'h000, 0,0,0,11'h100,1,16'd8});
        vecs.push_back('{0,1,16'd0,1,0,0,11'h000, 0,0,0,11'h100,0,16'd0});
        vecs.push_back('{0,0,16'd0,1,1,0,11'h077, 0,0,0,11'h100,0,16'd0});
        vecs.push_back('{0,0,16'd0,0,0,1,11'h000, 0,0,0,11'h100,0,16'd0});
        vecs.push_back('{0,1,16'd0,0,0,0,11'h000, 0,0,0,11'h100,0,16'd0});
        vecs.push_back('{0,1,16'hFFFF,0,0,0,11'h000, 0,0,0,11'h100,1,16'hFFFF});
        vecs.push_back('{0,0,16'd0,1,0,0,11'h000, 0,0,0,11'h100,1,16'hFFFE});
        vecs.push_back('{0,1,16'd7,1,0,0,11'h000, 0,0,0,11'h100,1,16'd7});
        vecs.push_back('{0,0,16'd0,0,0,0,11'h000, 0,0,0,11'h100,1,16'd7});
        vecs.push_back('{0,1,16'd0,0,0,0,11'h000, 0,0,0,11'h100,0,16'd0});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].q, vecs[i].ce,
                 vecs[i].h, vecs[i].a, vecs[i].pc);
            check_all($sformatf("vec%0d", i), vecs[i].e_iclk,
                      vecs[i].e_ihalt, vecs[i].e_cause, vecs[i].e_spc,
                      vecs[i].e_armed, vecs[i].e_rem);
        end

        // Q=4 with three stalled cycles: expiry lands 7 edges after load
        ce_pat  = '{1, 0, 0, 0, 1, 1, 1};
        rem_exp = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd2, 16'd1, 16'd0};
        clk_exp = '{0, 0, 0, 0, 0, 0, 1};
        step(0, 1, 16'd4, 0, 0, 0, 11'h000);
        check("stall.load", remaining, 16'd4);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 16'd0, ce_pat[i], 0, 0, 11'h03C);
            check($sformatf("stall.rem%0d", i), remaining, rem_exp[i]);
            check($sformatf("stall.iclk%0d", i), 16'(int_clk),
                  16'(clk_exp[i]));
        end
        check("stall.cause", 16'(cause), 16'd1);
        step(0, 0, 16'd0, 0, 0, 1, 11'h000);
        check_all("stall.ack", 0, 0, 0, 11'h03C, 0, 16'd0);

        // Reset mid-COUNTING with remaining=3, halt also high
        step(0, 1, 16'd3, 0, 0, 0, 11'h000);
        check("rstc.load", remaining, 16'd3);
        step(1, 0, 16'd0, 1, 1, 0, 11'h011);
        check_all("rstc", 0, 0, 0, 11'h000, 0, 16'd0);
        step(0, 0, 16'd0, 1, 0, 0, 11'h000);
        check_all("rstc.after", 0, 0, 0, 11'h000, 0, 16'd0);

        // Reset mid-PENDING
        step(0, 1, 16'd2, 0, 0, 0, 11'h000);
        step(0, 0, 16'd0, 1, 0, 0, 11'h000);
        step(0, 0, 16'd0, 1, 0, 0, 11'h003);
        check_all("rstp.exp", 1, 0, 1, 11'h003, 0, 16'd0);
        step(1, 0, 16'd0, 0, 0, 0, 11'h000);
        check_all("rstp", 0, 0, 0, 11'h000, 0, 16'd0);
        step(0, 0, 16'd0, 1, 1, 0, 11'h000);
        check_all("rstp.after", 0, 0, 0, 11'h000, 0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
